// File: rtl/vanilla_remote_req_responder_pkg.sv
// Shared types for the vanilla remote-request responder: request/response
// structs, AMO opcodes and the responder FSM state encoding.
package vanilla_remote_req_responder_pkg;

    typedef enum logic [1:0] {
        e_vanilla_amoswap = 2'b00,
        e_vanilla_amoor   = 2'b01,
        e_vanilla_amoadd  = 2'b10
    } bsg_vanilla_amo_type_e;

    typedef struct packed {
        logic       float_wb;
        logic       is_unsigned_op;
        logic       is_byte_op;
        logic       is_hex_op;
        logic [1:0] part_sel;
    } load_info_s;

    typedef struct packed {
        logic                  write_not_read;
        logic                  is_amo_op;
        bsg_vanilla_amo_type_e amo_type;
        logic [3:0]            mask;
        load_info_s            load_info;
        logic [4:0]            reg_id;
        logic [31:0]           data;
        logic [31:0]           addr;
    } remote_req_s;

    typedef struct packed {
        logic        float_wb;
        logic        is_unsigned_op;
        logic        is_byte_op;
        logic        is_hex_op;
        logic [1:0]  part_sel;
        logic [4:0]  reg_id;
        logic [31:0] data;
    } remote_load_resp_s;

    typedef enum logic [1:0] {
        StIdle,
        StLdWait,
        StAmoWr,
        StResp
    } bsg_vanilla_resp_state_e;

    // Response header for a request; data is filled in later. AMOs return a full word.
    function automatic remote_load_resp_s resp_fields(remote_req_s req);
        remote_load_resp_s r;
        r        = '0;
        r.reg_id = req.reg_id;
        if (!req.is_amo_op) begin
            r.float_wb       = req.load_info.float_wb;
            r.is_unsigned_op = req.load_info.is_unsigned_op;
            r.is_byte_op     = req.load_info.is_byte_op;
            r.is_hex_op      = req.load_info.is_hex_op;
            r.part_sel       = req.load_info.part_sel;
        end
        return r;
    endfunction

endpackage

// File: rtl/vanilla_remote_req_responder_if.sv
// Request/response handshake between the network endpoint and the responder.
interface vanilla_remote_req_responder_if;
    import vanilla_remote_req_responder_pkg::*;

    logic              v;
    remote_req_s       req;
    logic              ready;
    logic              resp_v;
    remote_load_resp_s resp;
    logic              resp_yumi;

    modport master (output v, req, resp_yumi, input ready, resp_v, resp);
    modport slave  (input v, req, resp_yumi, output ready, resp_v, resp);

endinterface

// File: rtl/vanilla_remote_req_responder_amo_alu.sv
// Combinational AMO datapath: computes the value written back for swap/or/add.
module vanilla_remote_req_responder_amo_alu
    import vanilla_remote_req_responder_pkg::*;
(
    input  bsg_vanilla_amo_type_e amo_type_i,
    input  logic [31:0]           old_i,
    input  logic [31:0]           operand_i,
    output logic [31:0]           new_o
);

    // The unused encoding falls through to swap.
    always_comb begin
        new_o = operand_i;
        unique case (amo_type_i)
            e_vanilla_amoor:  new_o = old_i | operand_i;
            e_vanilla_amoadd: new_o = old_i + operand_i;
            default:          new_o = operand_i;
        endcase
    end

endmodule

// File: rtl/vanilla_remote_req_responder.sv
// Target-side endpoint for vanilla remote requests: services loads, masked stores
// and AMOs against a 1-cycle synchronous word SRAM and returns load/AMO data.
module vanilla_remote_req_responder
    import vanilla_remote_req_responder_pkg::*;
#(
    parameter int unsigned mem_addr_width_p = 10,
    parameter int unsigned addr_offset_p    = 0
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    vanilla_remote_req_responder_if.slave link,
    output logic                        mem_v_o,
    output logic                        mem_w_o,
    output logic [mem_addr_width_p-1:0] mem_addr_o,
    output logic [31:0]                 mem_data_o,
    output logic [3:0]                  mem_mask_o,
    input  logic [31:0]                 mem_data_i,
    output logic                        addr_err_o
);

    localparam logic [29:0] AddrOffset = 30'(addr_offset_p);

    bsg_vanilla_resp_state_e     state_q, state_d;
    remote_load_resp_s           resp_q, resp_d;
    logic [mem_addr_width_p-1:0] widx_q, widx_d;
    bsg_vanilla_amo_type_e       amo_type_q, amo_type_d;
    logic [31:0]                 operand_q, operand_d;

    logic [29:0] widx;
    logic        in_range;
    logic        is_store;
    logic [31:0] amo_new;
    logic        unused_addr_lsb;

    assign widx            = link.req.addr[31:2] - AddrOffset;
    assign in_range        = (widx >> mem_addr_width_p) == '0;
    assign is_store        = link.req.write_not_read & ~link.req.is_amo_op;
    assign unused_addr_lsb = ^link.req.addr[1:0];

    vanilla_remote_req_responder_amo_alu amo_alu (
        .amo_type_i (amo_type_q),
        .old_i      (mem_data_i),
        .operand_i  (operand_q),
        .new_o      (amo_new)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            resp_q     <= '0;
            widx_q     <= '0;
            amo_type_q <= e_vanilla_amoswap;
            operand_q  <= '0;
        end else begin
            state_q    <= state_d;
            resp_q     <= resp_d;
            widx_q     <= widx_d;
            amo_type_q <= amo_type_d;
            operand_q  <= operand_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        resp_d     = resp_q;
        widx_d     = widx_q;
        amo_type_d = amo_type_q;
        operand_d  = operand_q;
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_addr_o = widx[mem_addr_width_p-1:0];
        mem_data_o = link.req.data;
        mem_mask_o = link.req.mask;
        addr_err_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (link.v) begin
                    if (!in_range) begin
                        // Loads/AMOs still answer with zero data so the requester's scoreboard clears.
                        addr_err_o = 1'b1;
                        if (!is_store) begin
                            resp_d  = resp_fields(link.req);
                            state_d = StResp;
                        end
                    end else if (is_store) begin
                        mem_v_o = 1'b1;
                        mem_w_o = 1'b1;
                    end else begin
                        mem_v_o    = 1'b1;
                        resp_d     = resp_fields(link.req);
                        widx_d     = widx[mem_addr_width_p-1:0];
                        amo_type_d = link.req.amo_type;
                        operand_d  = link.req.data;
                        state_d    = link.req.is_amo_op ? StAmoWr : StLdWait;
                    end
                end
            end
            StLdWait: begin
                resp_d.data = mem_data_i;
                state_d     = StResp;
            end
            StAmoWr: begin
                mem_v_o     = 1'b1;
                mem_w_o     = 1'b1;
                mem_addr_o  = widx_q;
                mem_data_o  = amo_new;
                mem_mask_o  = 4'hF;
                resp_d.data = mem_data_i;
                state_d     = StResp;
            end
            StResp: begin
                if (link.resp_yumi) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign link.ready  = (state_q == StIdle);
    assign link.resp_v = (state_q == StResp);
    assign link.resp   = resp_q;

    yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) link.resp_yumi |-> link.resp_v);

    amo_type_legal: assert property (
        @(posedge clk_i) disable iff (reset_i) (state_q == StAmoWr) |-> (amo_type_q != 2'b11));

endmodule
